hazard_scoreboard_n: RTL and testbench

- Parametrised hazard unit for the N-issue in-order pipeline; sits between decode (ID) and the EX operand muxes.
- Keeps its own registered copies of per-lane destination info for the ID/EX, EX/MEM and MEM/WB stages, so no stage buses need to be routed in.
- Combinationally produces a whole-bundle load-use stall and per-lane, per-operand forwarding selects.
- Generalises the fixed two-lane A/B scheme to `LANES` lanes, adds flush handling, and uses youngest-lane-wins forwarding priority.

---
 rtl/hazard_scoreboard_n.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard_n.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_n.sv
// hazard_scoreboard_n
// Hazard unit for an N-issue in-order pipeline, placed between decode (ID)
// and the EX operand muxes. It keeps private copies of the per-lane
// destination info for ID/EX, EX/MEM and MEM/WB. From these it produces a
// whole-bundle load-use stall and per-lane, per-operand forwarding selects.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset (clears valids)
//   id_valid[LANES]      lane holds a real instruction in ID
//   id_rs1/rs2/rd        packed per lane, lane k at [k*REG_W +: REG_W]
//   id_wb, id_load       lane writes the register file / lane is a load
//   flush                redirect; kills the ID bundle
//   stall                hold PC and IF/ID, bubble into EX
//   stall_lane           per-lane load-use victim flags
//   fwd_a, fwd_b         per-lane operand selects, {stage[1:0], lane[LW-1:0]}
//                        stage 1 = ID/EX (intra-bundle), 2 = EX/MEM,
//                        3 = MEM/WB, 0 = register file
module hazard_scoreboard_n #(
  parameter int LANES = 2,
  parameter int REG_W = 5,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int FW    = 2 + LW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       id_valid,
  input  logic [LANES*REG_W-1:0] id_rs1,
  input  logic [LANES*REG_W-1:0] id_rs2,
  input  logic [LANES*REG_W-1:0] id_rd,
  input  logic [LANES-1:0]       id_wb,
  input  logic [LANES-1:0]       id_load,
  input  logic                   flush,
  output logic                   stall,
  output logic [LANES-1:0]       stall_lane,
  output logic [LANES*FW-1:0]    fwd_a,
  output logic [LANES*FW-1:0]    fwd_b
);

  // ID/EX record
  logic [LANES-1:0]       ix_vld_q, ix_vld_d;
  logic [LANES*REG_W-1:0] ix_rs1_q, ix_rs2_q, ix_rd_q;
  logic [LANES-1:0]       ix_wb_q, ix_load_q;
  // EX/MEM record
  logic [LANES-1:0]       xm_vld_q;
  logic [LANES*REG_W-1:0] xm_rd_q;
  logic [LANES-1:0]       xm_wb_q;
  // MEM/WB record
  logic [LANES-1:0]       mw_vld_q;
  logic [LANES*REG_W-1:0] mw_rd_q;
  logic [LANES-1:0]       mw_wb_q;

  logic [LANES-1:0] ix_wr, xm_wr, mw_wr;

  function automatic logic [REG_W-1:0] fld(input logic [LANES*REG_W-1:0] v,
                                           input int k);
    return v[k*REG_W +: REG_W];
  endfunction

  // A stage entry only counts as a producer if it really writes a nonzero reg.
  always_comb begin
    ix_wr = '0;
    xm_wr = '0;
    mw_wr = '0;
    for (int j = 0; j < LANES; j++) begin
      ix_wr[j] = ix_vld_q[j] && ix_wb_q[j] && (fld(ix_rd_q, j) != '0);
      xm_wr[j] = xm_vld_q[j] && xm_wb_q[j] && (fld(xm_rd_q, j) != '0);
      mw_wr[j] = mw_vld_q[j] && mw_wb_q[j] && (fld(mw_rd_q, j) != '0);
    end
  end

  // Load-use detection: any ID lane reading a load destination now in EX.
  always_comb begin
    logic victim;
    stall_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      victim = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        if (ix_wr[j] && ix_load_q[j] &&
            ((fld(ix_rd_q, j) == fld(id_rs1, k)) ||
             (fld(ix_rd_q, j) == fld(id_rs2, k))))
          victim = 1'b1;
      end
      stall_lane[k] = id_valid[k] && victim && !flush;
    end
    stall = |stall_lane;
  end

  // Forwarding: scan oldest stage first, lanes low to high, so the last hit
  // written is the youngest producer (nearest stage, highest lane).
  always_comb begin
    logic [REG_W-1:0] src_a, src_b;
    logic [FW-1:0]    sel_a, sel_b;
    fwd_a = '0;
    fwd_b = '0;
    for (int k = 0; k < LANES; k++) begin
      src_a = fld(ix_rs1_q, k);
      src_b = fld(ix_rs2_q, k);
      sel_a = '0;
      sel_b = '0;
      for (int j = 0; j < LANES; j++) begin
        if (mw_wr[j] && fld(mw_rd_q, j) == src_a) sel_a = {2'd3, LW'(j)};
        if (mw_wr[j] && fld(mw_rd_q, j) == src_b) sel_b = {2'd3, LW'(j)};
      end
      for (int j = 0; j < LANES; j++) begin
        if (xm_wr[j] && fld(xm_rd_q, j) == src_a) sel_a = {2'd2, LW'(j)};
        if (xm_wr[j] && fld(xm_rd_q, j) == src_b) sel_b = {2'd2, LW'(j)};
      end
      // Only older lanes of the same bundle may feed lane k.
      for (int j = 0; j < LANES; j++) begin
        if (j < k && ix_wr[j] && fld(ix_rd_q, j) == src_a) sel_a = {2'd1, LW'(j)};
        if (j < k && ix_wr[j] && fld(ix_rd_q, j) == src_b) sel_b = {2'd1, LW'(j)};
      end
      if (!ix_vld_q[k] || src_a == '0) sel_a = '0;
      if (!ix_vld_q[k] || src_b == '0) sel_b = '0;
      fwd_a[k*FW +: FW] = sel_a;
      fwd_b[k*FW +: FW] = sel_b;
    end
  end

  // A stalled or flushed bundle enters EX as a bubble.
  always_comb begin
    ix_vld_d = (flush || stall) ? '0 : id_valid;
  end

  // Control: stage valids, the only state that reset touches.
  always_ff @(posedge clk) begin
    if (reset) begin
      ix_vld_q <= '0;
      xm_vld_q <= '0;
      mw_vld_q <= '0;
    end else begin
      ix_vld_q <= ix_vld_d;
      xm_vld_q <= ix_vld_q;
      mw_vld_q <= xm_vld_q;
    end
  end

  // Data: qualified by the valids above, so no reset needed.
  always_ff @(posedge clk) begin
    ix_rs1_q  <= id_rs1;
    ix_rs2_q  <= id_rs2;
    ix_rd_q   <= id_rd;
    ix_wb_q   <= id_wb;
    ix_load_q <= id_load;
    xm_rd_q   <= ix_rd_q;
    xm_wb_q   <= ix_wb_q;
    mw_rd_q   <= xm_rd_q;
    mw_wb_q   <= xm_wb_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard_n.sv
module tb_hazard_scoreboard_n;
  localparam int LANES = 2;
  localparam int REG_W = 5;
  localparam int FW    = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [LANES-1:0]       id_valid;
  logic [LANES*REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic [LANES-1:0]       id_wb, id_load;
  logic                   flush;
  logic                   stall;
  logic [LANES-1:0]       stall_lane;
  logic [LANES*FW-1:0]    fwd_a, fwd_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       st;
    logic [1:0] sl;
    logic [5:0] fa;
    logic [5:0] fb;
  } exp_t;
  exp_t sbq[$];

  hazard_scoreboard_n #(.LANES(LANES), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_wb(id_wb), .id_load(id_load), .flush(flush),
    .stall(stall), .stall_lane(stall_lane), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_wb = '0; id_load = '0; flush = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic v, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] d,
                          input logic w, input logic l);
    id_valid[k] = v;
    id_rs1[k*REG_W +: REG_W] = r1;
    id_rs2[k*REG_W +: REG_W] = r2;
    id_rd[k*REG_W +: REG_W]  = d;
    id_wb[k] = w;
    id_load[k] = l;
  endtask

  // Inputs for this cycle are already driven; expectation goes into the
  // scoreboard, is retired against the DUT mid-cycle, then time advances.
  task automatic step(input string tag, input logic st, input logic [1:0] sl,
                      input logic [5:0] fa, input logic [5:0] fb);
    exp_t e, o;
    e.tag = tag; e.st = st; e.sl = sl; e.fa = fa; e.fb = fb;
    sbq.push_back(e);
    #1;
    o = sbq.pop_front();
    chk({o.tag, ".stall"}, {31'd0, stall}, {31'd0, o.st});
    chk({o.tag, ".stall_lane"}, {30'd0, stall_lane}, {30'd0, o.sl});
    chk({o.tag, ".fwd_a"}, {26'd0, fwd_a}, {26'd0, o.fa});
    chk({o.tag, ".fwd_b"}, {26'd0, fwd_b}, {26'd0, o.fb});
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset with a matching, loading bundle on the inputs.
    reset = 1'b1;
    idle();
    set_lane(0, 1, 5'd0, 5'd4, 5'd3, 1, 1);
    set_lane(1, 1, 5'd3, 5'd0, 5'd4, 1, 1);
    @(negedge clk);
    step("rst_during", 0, 2'b00, 6'o00, 6'o00);
    reset = 1'b0;
    step("rst_release", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("rst_captured", 0, 2'b00, 6'o20, 6'o00);

    // Load-use across lanes.
    rst_pulse();
    set_lane(0, 1, 5'd0, 5'd0, 5'd5, 1, 1);
    step("lu_c0", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(1, 1, 5'd5, 5'd0, 5'd6, 1, 0);
    step("lu_c1", 1, 2'b10, 6'o00, 6'o00);
    step("lu_c2", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("lu_c3", 0, 2'b00, 6'o60, 6'o00);
    step("lu_c4", 0, 2'b00, 6'o00, 6'o00);

    // Load-use on lane 0 via rs2, consumer fed from MEM_WB lane 1.
    rst_pulse();
    set_lane(1, 1, 5'd0, 5'd0, 5'd20, 1, 1);
    step("lu0_c0", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(0, 1, 5'd0, 5'd20, 5'd21, 1, 0);
    step("lu0_c1", 1, 2'b01, 6'o00, 6'o00);
    step("lu0_c2", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("lu0_c3", 0, 2'b00, 6'o00, 6'o07);

    // Intra-bundle forwarding.
    rst_pulse();
    set_lane(0, 1, 5'd1, 5'd2, 5'd7, 1, 0);
    set_lane(1, 1, 5'd3, 5'd7, 5'd8, 1, 0);
    step("intra_c0", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("intra_c1", 0, 2'b00, 6'o00, 6'o20);
    step("intra_c2", 0, 2'b00, 6'o00, 6'o00);

    // Youngest lane / nearest stage priority.
    rst_pulse();
    set_lane(0, 1, 5'd0, 5'd0, 5'd9, 1, 0);
    step("young_cm1", 0, 2'b00, 6'o00, 6'o00);
    set_lane(1, 1, 5'd0, 5'd0, 5'd9, 1, 0);
    step("young_c0", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(0, 1, 5'd9, 5'd0, 5'd10, 0, 0);
    set_lane(1, 1, 5'd9, 5'd0, 5'd11, 0, 0);
    step("young_c1", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("young_c2", 0, 2'b00, 6'o55, 6'o00);

    // Non-writers: rd=0 load, and a store with rd field 4.
    rst_pulse();
    set_lane(0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    step("nw_c0", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    set_lane(1, 1, 5'd0, 5'd0, 5'd4, 0, 0);
    step("nw_c1", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(0, 1, 5'd0, 5'd4, 5'd0, 0, 0);
    set_lane(1, 1, 5'd0, 5'd4, 5'd0, 0, 0);
    step("nw_c2", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("nw_c3", 0, 2'b00, 6'o00, 6'o00);

    // Flush wins over stall; the load still moves down the pipe.
    rst_pulse();
    set_lane(0, 1, 5'd0, 5'd0, 5'd12, 1, 1);
    step("fl_c0", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(1, 1, 5'd0, 5'd12, 5'd14, 1, 0);
    flush = 1'b1;
    step("fl_c1", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(0, 1, 5'd12, 5'd0, 5'd0, 0, 0);
    step("fl_c2", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("fl_c3", 0, 2'b00, 6'o06, 6'o00);

    // Reset during a stall kills the load.
    rst_pulse();
    set_lane(0, 1, 5'd0, 5'd0, 5'd13, 1, 1);
    step("rs_c0", 0, 2'b00, 6'o00, 6'o00);
    idle();
    set_lane(1, 1, 5'd13, 5'd0, 5'd15, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step("rs_c2", 0, 2'b00, 6'o00, 6'o00);
    idle();
    step("rs_c3", 0, 2'b00, 6'o00, 6'o00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
